gearbox_64_48: RTL and testbench

Width-conversion gearbox from a 64-bit datapath to a 48-bit datapath, handled as 16-bit lanes: four lanes in per input word, three lanes out per output word. It sits on the transmit-side return path of the pcs25g datapath, between a 64-bit upstream producer and a 48-bit downstream consumer. Flow control runs both ways: a ready level to upstream and a ready level from downstream.

---
 rtl/pcs25g_gearbox_pkg.sv | 21 ++
 rtl/gearbox_64_48_if.sv | 27 ++
 rtl/gearbox_64_48.sv | 75 +++++++
 tb/tb_gearbox_64_48.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pcs25g_gearbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcs25g_gearbox_pkg
// Brief    : Lane geometry shared by the pcs25g 64<->48 gearboxes.
// Revision : 1.0  initial release
// ============================================================================
package pcs25g_gearbox_pkg;
   localparam int LANE_W    = 16;
   localparam int IN_LANES  = 4;
   localparam int OUT_LANES = 3;
   localparam int BUF_LANES = 8;
   localparam int CNT_W     = 4;

   localparam int IN_W  = LANE_W * IN_LANES;
   localparam int OUT_W = LANE_W * OUT_LANES;
   localparam int BUF_W = LANE_W * BUF_LANES;

   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [LANE_W-1:0] lane_t;
endpackage
`default_nettype wire

// File: rtl/gearbox_64_48_if.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_64_48_if
// Brief    : Upstream 64-bit and downstream 48-bit handshake bundle.
// Revision : 1.0  initial release
// ============================================================================
interface gearbox_64_48_if;
   import pcs25g_gearbox_pkg::*;

   logic [IN_W-1:0]  in_data;
   logic             in_datavalid;
   logic             out_idle;
   logic [OUT_W-1:0] out_data;
   logic             out_datavalid;
   logic             in_idle;

   modport master (
      output in_data, in_datavalid, in_idle,
      input  out_idle, out_data, out_datavalid
   );

   modport slave (
      input  in_data, in_datavalid, in_idle,
      output out_idle, out_data, out_datavalid
   );
endinterface
`default_nettype wire

// File: rtl/gearbox_64_48.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_64_48
// Brief    : 64-bit to 48-bit lane gearbox, 8-lane buffer, two-way flow control.
//            GEARBOX_64_48_ASSERT_EN enables fatal protocol checks.
// Revision : 1.0  initial release
// ============================================================================
module gearbox_64_48
   import pcs25g_gearbox_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_enable,
   output logic            empty_save,
   gearbox_64_48_if.slave  bus
);

   cnt_t             cnt_q, cnt_d;
   cnt_t             wr_lane;
   logic [BUF_W-1:0] buf_q, buf_d, base;
   logic             fire, acc;

   // Readiness comes from the registered count only, never from this cycle's output.
   assign bus.out_idle      = (cnt_q <= cnt_t'(IN_LANES));
   assign fire              = in_enable & bus.in_idle & (cnt_q >= cnt_t'(OUT_LANES));
   assign acc               = in_enable & bus.in_datavalid & bus.out_idle;
   assign bus.out_datavalid = fire;
   assign bus.out_data      = buf_q[OUT_W-1:0];
   assign empty_save        = (cnt_q == 4'd0) | (cnt_q == 4'd3) | (cnt_q == 4'd6);

   always_comb begin
      base    = fire ? (buf_q >> OUT_W) : buf_q;
      wr_lane = fire ? (cnt_q - cnt_t'(OUT_LANES)) : cnt_q;
      buf_d   = base;
      if (acc) begin
         case (wr_lane)
            4'd0:    buf_d[LANE_W*0 +: IN_W] = bus.in_data;
            4'd1:    buf_d[LANE_W*1 +: IN_W] = bus.in_data;
            4'd2:    buf_d[LANE_W*2 +: IN_W] = bus.in_data;
            4'd3:    buf_d[LANE_W*3 +: IN_W] = bus.in_data;
            4'd4:    buf_d[LANE_W*4 +: IN_W] = bus.in_data;
            default: buf_d = base;
         endcase
      end
      cnt_d = cnt_q + (acc  ? cnt_t'(IN_LANES)  : '0)
                    - (fire ? cnt_t'(OUT_LANES) : '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
         buf_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         buf_q <= buf_d;
      end
   end

`ifdef GEARBOX_64_48_ASSERT_EN
   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!bus.in_datavalid | bus.out_idle)
            else $fatal(1, "gearbox_64_48: in_datavalid while out_idle low");
         assert (!bus.out_datavalid | bus.in_idle)
            else $fatal(1, "gearbox_64_48: out_datavalid while in_idle low");
         assert (cnt_q <= cnt_t'(BUF_LANES))
            else $fatal(1, "gearbox_64_48: lane count above buffer depth");
      end
   end
`else
   // Checks compiled out; a word offered while not ready is simply not accepted.
`endif

endmodule
`default_nettype wire

// File: tb/tb_gearbox_64_48.sv
`default_nettype none
// ============================================================================
// Module   : tb_gearbox_64_48
// Brief    : Directed self-checking bench for gearbox_64_48.
// Revision : 1.0  initial release
// ============================================================================
module tb_gearbox_64_48;
   import pcs25g_gearbox_pkg::*;

   logic clk       = 1'b0;
   logic reset_n   = 1'b0;
   logic in_enable = 1'b0;
   logic empty_save;

   int n_total = 0;
   int n_bad   = 0;

   gearbox_64_48_if bus ();

   gearbox_64_48 dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_enable  (in_enable),
      .empty_save (empty_save),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] W_A = 64'h0003_0002_0001_0000;
   localparam logic [63:0] W_B = 64'h0007_0006_0005_0004;
   localparam logic [63:0] W_C = 64'hdead_beef_cafe_f00d;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic en, input logic dv, input logic [63:0] d, input logic idle);
      @(negedge clk);
      in_enable        = en;
      bus.in_datavalid = dv;
      bus.in_data      = d;
      bus.in_idle      = idle;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n          = 1'b0;
      in_enable        = 1'b1;
      bus.in_datavalid = 1'b0;
      bus.in_data      = '0;
      bus.in_idle      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int in_idx, out_lane, n_out, cyc, idle_cnt;

      bus.in_datavalid = 1'b0;
      bus.in_data      = '0;
      bus.in_idle      = 1'b1;

      // Reset, then a single word.
      do_reset();
      #1;
      check_val("rst_out_idle",   64'(bus.out_idle),      64'd1);
      check_val("rst_empty_save", 64'(empty_save),        64'd1);
      check_val("rst_dv",         64'(bus.out_datavalid), 64'd0);
      check_val("rst_data",       64'(bus.out_data),      64'd0);

      drive(1'b1, 1'b1, W_A, 1'b1);
      check_val("t1_no_comb_path", 64'(bus.out_datavalid), 64'd0);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t1_dv",       64'(bus.out_datavalid), 64'd1);
      check_val("t1_data",     64'(bus.out_data),      64'h0002_0001_0000);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t1_cnt1_dv",  64'(bus.out_datavalid), 64'd0);
      check_val("t1_cnt1_rdy", 64'(bus.out_idle),      64'd1);
      check_val("t1_cnt1_es",  64'(empty_save),        64'd0);
      check_val("t1_lane0",    64'(bus.out_data[15:0]), 64'h0003);

      // Second word appended behind the leftover lane.
      drive(1'b1, 1'b1, W_B, 1'b1);
      check_val("t2_cnt1_nofire", 64'(bus.out_datavalid), 64'd0);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t2_dv",    64'(bus.out_datavalid), 64'd1);
      check_val("t2_data",  64'(bus.out_data),      64'h0005_0004_0003);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t2_cnt2_dv",  64'(bus.out_datavalid), 64'd0);
      check_val("t2_cnt2_es",  64'(empty_save),        64'd0);
      check_val("t2_cnt2_rdy", 64'(bus.out_idle),      64'd1);
      check_val("t2_lanes",    64'(bus.out_data[31:0]), 64'h0007_0006);

      // Backpressure to full, then an illegal word at count 8.
      do_reset();
      drive(1'b1, 1'b1, W_A, 1'b0);
      check_val("t3_rdy0", 64'(bus.out_idle), 64'd1);
      drive(1'b1, 1'b1, W_B, 1'b0);
      check_val("t3_rdy4", 64'(bus.out_idle), 64'd1);
      drive(1'b1, 1'b1, W_C, 1'b0);
      check_val("t3_full_rdy", 64'(bus.out_idle),      64'd0);
      check_val("t3_full_es",  64'(empty_save),        64'd0);
      check_val("t3_full_dv",  64'(bus.out_datavalid), 64'd0);
      drive(1'b1, 1'b1, W_C, 1'b0);
      check_val("t3_drop_rdy", 64'(bus.out_idle), 64'd0);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t3_out0_dv",   64'(bus.out_datavalid), 64'd1);
      check_val("t3_out0_data", 64'(bus.out_data),      64'h0002_0001_0000);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t3_out1_dv",   64'(bus.out_datavalid), 64'd1);
      check_val("t3_out1_data", 64'(bus.out_data),      64'h0005_0004_0003);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t3_cnt2_dv",  64'(bus.out_datavalid), 64'd0);
      check_val("t3_cnt2_rdy", 64'(bus.out_idle),      64'd1);
      check_val("t3_cnt2_es",  64'(empty_save),        64'd0);
      check_val("t3_lanes",    64'(bus.out_data[31:0]), 64'h0007_0006);

      // Clock-enable gap at count 5.
      do_reset();
      drive(1'b1, 1'b1, W_A, 1'b0);
      drive(1'b1, 1'b1, W_B, 1'b1);
      check_val("t5_fire_dv",   64'(bus.out_datavalid), 64'd1);
      check_val("t5_fire_data", 64'(bus.out_data),      64'h0002_0001_0000);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, W_C, 1'b1);
         check_val("t5_gap_dv",   64'(bus.out_datavalid), 64'd0);
         check_val("t5_gap_data", 64'(bus.out_data),      64'h0005_0004_0003);
         check_val("t5_gap_rdy",  64'(bus.out_idle),      64'd0);
         check_val("t5_gap_es",   64'(empty_save),        64'd0);
      end
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t5_resume_dv",   64'(bus.out_datavalid), 64'd1);
      check_val("t5_resume_data", 64'(bus.out_data),      64'h0005_0004_0003);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("t5_after_dv",    64'(bus.out_datavalid), 64'd0);
      check_val("t5_after_lanes", 64'(bus.out_data[31:0]), 64'h0007_0006);

      // Streaming: count cycles through 4,5,2,6,3, so 3 accepts per 5 cycles.
      do_reset();
      in_idx   = 0;
      out_lane = 0;
      n_out    = 0;
      cyc      = 0;
      idle_cnt = 0;
      while (n_out < 400 && cyc < 3000) begin
         @(negedge clk);
         in_enable   = 1'b1;
         bus.in_idle = 1'b1;
         if (cyc >= 10 && cyc < 110 && bus.out_idle) idle_cnt++;
         if (bus.out_idle && in_idx < 300) begin
            bus.in_datavalid = 1'b1;
            bus.in_data      = {16'(4*in_idx+3), 16'(4*in_idx+2), 16'(4*in_idx+1), 16'(4*in_idx)};
            in_idx++;
         end else begin
            bus.in_datavalid = 1'b0;
         end
         #1;
         if (bus.out_datavalid) begin
            check_val("stream_data", 64'(bus.out_data),
                      64'({16'(out_lane+2), 16'(out_lane+1), 16'(out_lane)}));
            out_lane += 3;
            n_out++;
         end
         cyc++;
      end
      check_val("stream_n_out", 64'(n_out),    64'd400);
      check_val("stream_n_in",  64'(in_idx),   64'd300);
      check_val("stream_duty",  64'(idle_cnt), 64'd60);
      drive(1'b1, 1'b0, '0, 1'b1);
      check_val("stream_end_es",  64'(empty_save),        64'd1);
      check_val("stream_end_rdy", 64'(bus.out_idle),      64'd1);
      check_val("stream_end_dv",  64'(bus.out_datavalid), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
